// File: rtl/seeg_regs_pkg.sv
// Shared definitions for the SEEG AXI4-Lite register block:
// offsets, response codes, FSM states and the address decoder.
package seeg_regs_pkg;

    localparam logic [7:0] CTRL_OFS       = 8'h00;
    localparam logic [7:0] STATUS_OFS     = 8'h04;
    localparam logic [7:0] SCRATCH_OFS    = 8'h08;
    localparam logic [7:0] VERSION_OFS    = 8'h0C;
    localparam logic [7:0] MISO_DELAY_OFS = 8'h50;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        WS_IDLE,
        WS_RESP
    } wstate_t;

    typedef enum logic {
        RS_IDLE,
        RS_DATA
    } rstate_t;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_STATUS,
        REG_SCRATCH,
        REG_VERSION,
        REG_MISO_DELAY,
        REG_NONE
    } reg_sel_t;

    // Word index is byte address bits [6:2].
    function automatic reg_sel_t decode(input logic [4:0] widx);
        reg_sel_t sel;
        sel = REG_NONE;
        if (widx == CTRL_OFS[6:2])
            sel = REG_CTRL;
        else if (widx == STATUS_OFS[6:2])
            sel = REG_STATUS;
        else if (widx == SCRATCH_OFS[6:2])
            sel = REG_SCRATCH;
        else if (widx == VERSION_OFS[6:2])
            sel = REG_VERSION;
        else if (widx == MISO_DELAY_OFS[6:2])
            sel = REG_MISO_DELAY;
        return sel;
    endfunction

    function automatic logic is_writable(input reg_sel_t sel);
        return (sel == REG_CTRL) || (sel == REG_SCRATCH) ||
               (sel == REG_MISO_DELAY);
    endfunction

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/seeg_axil_regs.sv
// AXI4-Lite responder for SEEG front-end configuration and status.
// Independent write/read FSMs; AW and W are captured in any order.
module seeg_axil_regs
    import seeg_regs_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] VERSION    = 32'h0001_0000,
    parameter int          N_MISO     = 8
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESET,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]              S_AXI_AWPROT,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [31:0]             S_AXI_WDATA,
    input  logic [3:0]              S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]              S_AXI_ARPROT,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [31:0]             S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    output logic                    acq_enable,
    output logic                    soft_rst,
    output logic [N_MISO*4-1:0]     miso_delay,
    input  logic [31:0]             status_in
);

    localparam int MW = N_MISO * 4;

    wstate_t ws_q, ws_d;
    rstate_t rs_q, rs_d;

    logic          aw_cap_q, w_cap_q;
    logic [4:0]    aw_idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [1:0]    bresp_q, rresp_q;
    logic [31:0]   rdata_q;
    logic          acq_q, soft_rst_q;
    logic [31:0]   scratch_q;
    logic [MW-1:0] miso_q;

    logic          aw_hs, w_hs, ar_hs, wr_fire;
    logic [4:0]    wr_idx;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;
    reg_sel_t      wr_sel, rd_sel;
    logic [31:0]   miso_word, miso_merged;
    logic [31:0]   rd_data;
    logic [1:0]    rd_resp;

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    // Fire on the edge where the second of AW/W is (or already was) held.
    assign wr_fire = (ws_q == WS_IDLE) & (aw_cap_q | aw_hs) & (w_cap_q | w_hs);
    assign wr_idx  = aw_cap_q ? aw_idx_q : S_AXI_AWADDR[6:2];
    assign wr_data = w_cap_q ? wdata_q : S_AXI_WDATA;
    assign wr_strb = w_cap_q ? wstrb_q : S_AXI_WSTRB;
    assign wr_sel  = decode(wr_idx);
    assign rd_sel  = decode(S_AXI_ARADDR[6:2]);

    assign miso_word   = 32'(miso_q);
    assign miso_merged = merge_bytes(miso_word, wr_data, wr_strb);

    assign S_AXI_BRESP = bresp_q;
    assign S_AXI_RDATA = rdata_q;
    assign S_AXI_RRESP = rresp_q;
    assign acq_enable  = acq_q;
    assign soft_rst    = soft_rst_q;
    assign miso_delay  = miso_q;

    logic unused;
    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR,
                      S_AXI_ARADDR, miso_merged};

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            ws_q <= WS_IDLE;
            rs_q <= RS_IDLE;
        end else begin
            ws_q <= ws_d;
            rs_q <= rs_d;
        end
    end

    always_comb begin
        ws_d          = ws_q;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        unique case (ws_q)
            WS_IDLE: begin
                S_AXI_AWREADY = ~aw_cap_q & ~S_AXI_ARESET;
                S_AXI_WREADY  = ~w_cap_q & ~S_AXI_ARESET;
                if (wr_fire)
                    ws_d = WS_RESP;
            end
            WS_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY)
                    ws_d = WS_IDLE;
            end
        endcase
    end

    always_comb begin
        rs_d          = rs_q;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        unique case (rs_q)
            RS_IDLE: begin
                S_AXI_ARREADY = ~S_AXI_ARESET;
                if (ar_hs)
                    rs_d = RS_DATA;
            end
            RS_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY)
                    rs_d = RS_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (rd_sel)
            REG_CTRL:       rd_data = {31'b0, acq_q};
            REG_STATUS:     rd_data = status_in;
            REG_SCRATCH:    rd_data = scratch_q;
            REG_VERSION:    rd_data = VERSION;
            REG_MISO_DELAY: rd_data = miso_word;
            default:        rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            aw_cap_q   <= 1'b0;
            w_cap_q    <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            acq_q      <= 1'b0;
            soft_rst_q <= 1'b0;
            scratch_q  <= '0;
            miso_q     <= '0;
        end else begin
            soft_rst_q <= 1'b0;
            if (wr_fire) begin
                aw_cap_q <= 1'b0;
                w_cap_q  <= 1'b0;
                bresp_q  <= is_writable(wr_sel) ? RESP_OKAY : RESP_SLVERR;
                case (wr_sel)
                    REG_CTRL: begin
                        if (wr_strb[0]) begin
                            acq_q      <= wr_data[0];
                            soft_rst_q <= wr_data[1];
                        end
                    end
                    REG_SCRATCH:
                        scratch_q <= merge_bytes(scratch_q, wr_data, wr_strb);
                    REG_MISO_DELAY:
                        miso_q <= miso_merged[MW-1:0];
                    default: ;
                endcase
            end else begin
                if (aw_hs) begin
                    aw_cap_q <= 1'b1;
                    aw_idx_q <= S_AXI_AWADDR[6:2];
                end
                if (w_hs) begin
                    w_cap_q <= 1'b1;
                    wdata_q <= S_AXI_WDATA;
                    wstrb_q <= S_AXI_WSTRB;
                end
            end
            // Registers update with <=, so a same-edge read sees old values.
            if (ar_hs) begin
                rdata_q <= rd_data;
                rresp_q <= rd_resp;
            end
        end
    end

endmodule

// File: tb/tb_seeg_axil_regs.sv
// Randomized AXI4-Lite bench for seeg_axil_regs with a
// transaction-level register model checked every cycle.
module tb_seeg_axil_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        acq_enable, soft_rst;
    logic [31:0] miso_delay;
    logic [31:0] status_in = '0;

    int n_vec = 0;
    int n_miscmp = 0;
    int soft_cnt = 0;
    bit armed = 0;

    always #5 clk = ~clk;

    seeg_axil_regs dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .acq_enable(acq_enable), .soft_rst(soft_rst),
        .miso_delay(miso_delay), .status_in(status_in)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void timeout(string nm);
        n_vec++;
        n_miscmp++;
        $display("FAIL timeout %s at %0t", nm, $time);
    endfunction

    // ---------------- behavioural register model ----------------
    bit          m_en, m_soft, m_awh, m_wh, m_bp, m_rp;
    logic [31:0] m_scr = '0, m_miso = '0, m_wd = '0, m_rdata = '0;
    logic [3:0]  m_ws = '0;
    logic [7:0]  m_aa = '0;
    logic [1:0]  m_bresp = '0, m_rresp = '0;

    function automatic logic [31:0] bytes(logic [31:0] o, logic [31:0] n, logic [3:0] s);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    function automatic void mread(input logic [7:0] a, output logic [31:0] d,
                                  output logic [1:0] r);
        d = '0;
        r = 2'b00;
        case (int'(a[6:2]))
            0:  d = {31'b0, m_en};
            1:  d = status_in;
            2:  d = m_scr;
            3:  d = 32'h0001_0000;
            20: d = m_miso;
            default: r = 2'b10;
        endcase
    endfunction

    function automatic void mwrite(logic [7:0] a, logic [31:0] d, logic [3:0] s);
        m_bresp = 2'b00;
        case (int'(a[6:2]))
            0: if (s[0]) begin
                m_en = d[0];
                m_soft = d[1];
            end
            2:  m_scr = bytes(m_scr, d, s);
            20: m_miso = bytes(m_miso, d, s);
            default: m_bresp = 2'b10;
        endcase
    endfunction

    // Predict the state after the coming clock edge from current inputs.
    function automatic void step();
        if (rst) begin
            {m_en, m_soft, m_awh, m_wh, m_bp, m_rp} = '0;
            m_scr = '0; m_miso = '0; m_bresp = '0; m_rresp = '0; m_rdata = '0;
            return;
        end
        if (m_rp) begin
            if (rready) m_rp = 0;
        end else if (arvalid) begin
            m_rp = 1;
            mread(araddr, m_rdata, m_rresp);
        end
        m_soft = 0;
        if (m_bp) begin
            if (bready) m_bp = 0;
        end else begin
            if (awvalid && !m_awh) begin m_awh = 1; m_aa = awaddr; end
            if (wvalid && !m_wh) begin m_wh = 1; m_wd = wdata; m_ws = wstrb; end
            if (m_awh && m_wh) begin
                mwrite(m_aa, m_wd, m_ws);
                m_bp = 1; m_awh = 0; m_wh = 0;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            chk("awready", awready, !rst && !m_bp && !m_awh);
            chk("wready", wready, !rst && !m_bp && !m_wh);
            chk("arready", arready, !rst && !m_rp);
            chk("bvalid", bvalid, m_bp);
            chk("rvalid", rvalid, m_rp);
            if (m_bp) chk("bresp", bresp, m_bresp);
            if (m_rp) begin
                chk("rdata", rdata, m_rdata);
                chk("rresp", rresp, m_rresp);
            end
            chk("acq_enable", acq_enable, m_en);
            chk("soft_rst", soft_rst, m_soft);
            chk("miso_delay", miso_delay, m_miso);
            if (soft_rst) soft_cnt++;
        end
        step();
    end

    initial forever begin
        @(posedge clk);
        #1 status_in = $urandom;
    end

    // ---------------- bus tasks (called at posedge+1) ----------------
    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int lead, input int bdel, output logic [1:0] resp);
        bit awd, wd, got;
        int t;
        awd = 0; wd = 0; got = 0; t = 0; resp = 2'b11;
        while (!(awd && wd) && t < 60) begin
            if (!awd && t >= (lead > 0 ? lead : 0)) begin awaddr = a; awvalid = 1; end
            if (!wd && t >= (lead < 0 ? -lead : 0)) begin
                wdata = d; wstrb = s; wvalid = 1;
            end
            @(negedge clk);
            if (awvalid && awready) awd = 1;
            if (wvalid && wready) wd = 1;
            @(posedge clk); #1;
            if (awd) awvalid = 0;
            if (wd) wvalid = 0;
            t++;
        end
        if (!(awd && wd)) begin
            timeout("aw/w handshake");
            awvalid = 0; wvalid = 0;
            return;
        end
        if (bdel < 0) return;
        t = 0;
        while (!got && t < 60) begin
            bready = (t >= bdel);
            @(negedge clk);
            if (bvalid && bready) begin resp = bresp; got = 1; end
            @(posedge clk); #1;
            t++;
        end
        bready = 0;
        if (!got) timeout("bvalid");
    endtask

    task automatic rd(input logic [7:0] a, input int rdel,
                      output logic [31:0] d, output logic [1:0] r);
        bit hs, got;
        int t;
        hs = 0; got = 0; t = 0; d = 'x; r = 2'b11;
        arvalid = 1; araddr = a;
        while (!hs && t < 60) begin
            @(negedge clk);
            hs = arready;
            @(posedge clk); #1;
            t++;
        end
        arvalid = 0;
        if (!hs) begin timeout("ar handshake"); return; end
        t = 0;
        while (!got && t < 60) begin
            rready = (t >= rdel);
            @(negedge clk);
            if (rvalid && rready) begin d = rdata; r = rresp; got = 1; end
            @(posedge clk); #1;
            t++;
        end
        rready = 0;
        if (!got) timeout("rvalid");
    endtask

    function automatic logic [7:0] pick_addr();
        logic [7:0] base;
        case ($urandom_range(0, 6))
            0: base = 8'h00;
            1: base = 8'h04;
            2: base = 8'h08;
            3: base = 8'h0C;
            4: base = 8'h50;
            5: base = 8'h40;
            default: base = 8'h10;
        endcase
        return base | 8'($urandom_range(0, 3)) | ($urandom_range(0, 1) ? 8'h80 : 8'h00);
    endfunction

    initial begin
        logic [1:0]  br, rr;
        logic [31:0] rv;
        logic [7:0]  a0, a1;
        logic [31:0] d0;

        @(posedge clk); #1;
        armed = 1;
        @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_bresp", bresp, 0);
        chk("rst_miso", miso_delay, 32'h0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("post_rst_ready", {awready, wready, arready}, 3'b111);
        @(posedge clk); #1;

        wr(8'h50, 32'h2222_2222, 4'hF, 0, 0, br);
        chk("miso_bresp", br, 2'b00);
        chk("miso_lit", miso_delay, 32'h2222_2222);
        rd(8'h50, 0, rv, rr);
        chk("miso_read", rv, 32'h2222_2222);

        wr(8'h08, 32'hDEAD_BEEF, 4'b0101, 3, 1, br);
        rd(8'h08, 0, rv, rr);
        chk("scratch_strb", rv, 32'h00AD_00EF);

        soft_cnt = 0;
        wr(8'h00, 32'h3, 4'hF, 0, 0, br);
        repeat (2) @(posedge clk);
        #1;
        chk("soft_pulses", soft_cnt, 1);
        chk("acq_lit", acq_enable, 1);
        rd(8'h00, 0, rv, rr);
        chk("ctrl_read", rv, 32'h1);

        wr(8'h0C, 32'hFFFF_FFFF, 4'hF, -1, 0, br);
        chk("ver_wr_resp", br, 2'b10);
        wr(8'h40, 32'h1234_5678, 4'hF, 2, 0, br);
        chk("unm_wr_resp", br, 2'b10);
        rd(8'h40, 0, rv, rr);
        chk("unm_rd_data", rv, 32'h0);
        chk("unm_rd_resp", rr, 2'b10);
        rd(8'h0C, 0, rv, rr);
        chk("ver_read", rv, 32'h0001_0000);

        fork
            wr(8'h08, 32'h5555_AAAA, 4'hF, 0, 5, br);
            rd(8'h08, 5, rv, rr);
        join
        chk("bp_bresp", br, 2'b00);
        chk("bp_pre_write_read", rv, 32'h00AD_00EF);

        for (int i = 0; i < 400; i++) begin
            a0 = pick_addr();
            a1 = pick_addr();
            d0 = $urandom;
            case ($urandom_range(0, 2))
                0: wr(a0, d0, 4'($urandom), $urandom_range(0, 6) - 3,
                      $urandom_range(0, 3), br);
                1: rd(a1, $urandom_range(0, 3), rv, rr);
                default: fork
                    wr(a0, d0, 4'($urandom), $urandom_range(0, 6) - 3,
                       $urandom_range(0, 3), br);
                    rd(a1, $urandom_range(0, 3), rv, rr);
                join
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        wr(8'h50, 32'h1357_9BDF, 4'hF, 0, 0, br);
        wr(8'h08, 32'h1234_5678, 4'hF, 0, -1, br);
        @(negedge clk);
        chk("abort_bvalid_pre", bvalid, 1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("abort_bvalid", bvalid, 0);
        chk("abort_miso", miso_delay, 32'h0);
        @(posedge clk); #1;
        rd(8'h08, 0, rv, rr);
        chk("abort_scratch", rv, 32'h0);
        wr(8'h08, 32'hCAFE_F00D, 4'hF, 0, 0, br);
        chk("post_abort_bresp", br, 2'b00);
        rd(8'h08, 1, rv, rr);
        chk("post_abort_read", rv, 32'hCAFE_F00D);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/seeg_axil_regs.md
# seeg_axil_regs

AXI4-Lite responder holding the SEEG front-end configuration and status registers. Sits behind the S_AXI port of the SEEG top level and answers the PS/VIP master's single-beat reads and writes. Among its registers is the per-line MISO sample-delay word at byte offset 80 (0x50). Its outputs drive the SPI acquisition engine and the AXI-Stream packetiser.

## Interface
- ADDR_WIDTH, 8: AXI byte-address width; only bits [6:2] are decoded.
- VERSION, 32'h0001_0000: constant returned by VERSION register.
- N_MISO, 8: number of MISO lines; one 4-bit delay field each, and N_MISO*4 must be ≤ 32.

- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel; AWPROT is ignored.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR_WIDTH/3/1/1  read address channel; ARPROT is ignored.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel.
- acq_enable  out  1  CTRL[0].
- soft_rst  out  1  one-cycle pulse when a write sets CTRL[1].
- miso_delay  out  N_MISO*4  MISO_DELAY register; nibble i = delay of line i in S_AXI_ACLK cycles.
- status_in  in  32  live status, sampled when read.

## Operation
- Register map (byte offset):
  - 0x00 CTRL: RW. Bit 0 is enable; bit 1 is soft reset and self-clears; other bits read 0.
  - 0x04 STATUS: RO, reads status_in.
  - 0x08 SCRATCH: RW, 32 bits.
  - 0x0C VERSION: RO.
  - 0x50 MISO_DELAY: RW, N_MISO*4 bits; unused upper bits read 0.
- Writes honour WSTRB per byte. A byte whose strobe is 0 is unchanged.
- A write to an RO register or an unmapped offset:
  - returns BRESP=SLVERR (2'b10);
  - has no side effect.
- A read from an unmapped offset returns RDATA=0 with RRESP=SLVERR.
- All other responses are OKAY (2'b00).
- Address bits [1:0] are ignored (word access only).
- Write FSM:
  - WS_IDLE: AWREADY=~aw_captured and WREADY=~w_captured.
    - AW and W may arrive in either order or in the same cycle. Each is latched independently.
    - Once both are held, the register is updated on that edge and the FSM goes to WS_RESP.
  - WS_RESP: BVALID=1; AWREADY=WREADY=0. On BVALID&BREADY, return to WS_IDLE with the captures cleared.
- Read FSM:
  - RS_IDLE: ARREADY=1. On handshake, capture the data and go to RS_DATA.
  - RS_DATA: RVALID=1, with RDATA/RRESP held stable. On RREADY, go to RS_IDLE.
- The read and write FSMs are fully independent.
  - If a read and a write target the same register in the same cycle, the read returns the pre-write value.

## Timing
- Reset values:
  - AWREADY=WREADY=ARREADY=0 during reset; each goes to 1 on the first cycle after reset.
  - BVALID=RVALID=0; BRESP=RRESP=0; RDATA=0.
  - CTRL=0, SCRATCH=0, MISO_DELAY=0.
  - acq_enable=0, soft_rst=0.
- Write latency:
  - The handshake completing AW+W in cycle N updates the register and outputs in cycle N+1.
  - BVALID rises in cycle N+1.
  - The next AW/W is accepted no earlier than the cycle after B completes.
- soft_rst is high for exactly cycle N+1 and then returns to 0. CTRL[1] always reads 0.
- Read latency:
  - AR handshake in cycle N puts RVALID and data in cycle N+1.
  - STATUS is sampled at the AR handshake edge.
  - Maximum throughput is one read per 2 cycles.
- Back-pressure: BVALID and RVALID stay high and their payloads stay stable until the matching ready.
- Reset mid-transaction aborts it:
  - all state returns to reset values on the next edge;
  - no response is issued for the aborted transfer.

## Structure
- Package seeg_regs_pkg holds:
  - offset localparams (CTRL_OFS=8'h00, STATUS_OFS=8'h04, SCRATCH_OFS=8'h08, VERSION_OFS=8'h0C, MISO_DELAY_OFS=8'h50);
  - the RESP_OKAY/RESP_SLVERR constants;
  - the write and read FSM state enums.
- A single module; the address decode is a function in the package, so no sub-module.

## Test plan
- Write 32'h2222_2222 to offset 80 with WSTRB=4'hF → BRESP=OKAY, miso_delay=32'h2222_2222 one cycle after the handshake, and a read of 80 returns 32'h2222_2222.
- W presented 3 cycles before AW to SCRATCH with 32'hDEAD_BEEF, WSTRB=4'b0101 starting from 0 → readback returns 32'h00AD_00EF.
- Write 32'h3 to CTRL → acq_enable=1 and soft_rst high for exactly one cycle, and a CTRL readback returns 32'h1.
- Write to VERSION, and write to offset 0x40 → both return BRESP=SLVERR with no register change; a read of 0x40 returns RDATA=0 with SLVERR, and a read of VERSION returns 32'h0001_0000.
- Hold BREADY=0 and RREADY=0 for 5 cycles → BVALID/RVALID and their payloads stay stable, and no further AW/W/AR is accepted until each is released.
- Assert S_AXI_ARESET while BVALID=1 → on the next cycle BVALID=0 and all registers are 0, and a subsequent write/read completes normally.
